// File: rtl/permute_burst_input_buffer.sv
// -----------------------------------------------------------------------------
// permute_burst_input_buffer
//
// Purpose:
//   Input stage in front of the permuter. Each write carries a data word, a
//   permutation mask and a side-band word. The entry is queued in a FIFO and
//   later expanded into one output beat per set mask bit, lowest bit first.
//   Each beat is tagged with its permutation index. The output side is a
//   valid/ready handshake that can be stalled per beat.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   wrEn           write request (ignored when permMaskIn is all zero)
//   dataIn         data word of the entry
//   permMaskIn     bit i set -> one beat with index i
//   extraIn        side-band word, repeated unchanged on every beat
//   fifoFullness   entries queued in the FIFO (holding register not counted)
//   full           FIFO holds 2**DEPTH_LOG2 entries
//   almostFull     free FIFO slots <= ALMOST_FULL_SLACK
//   overflow       sticky: a write was dropped because the FIFO was full
//   outValid       beat valid
//   outReady       consumer accepts the current beat
//   outData        data word of the entry being serialised
//   outPermIdx     permutation index of the current beat
//   outExtra       side-band word of the entry being serialised
//   outLast        current beat is the last beat of its entry
// -----------------------------------------------------------------------------
module permute_burst_input_buffer #(
   parameter int DATA_WIDTH        = 128,
   parameter int NUM_PERMUTES      = 6,
   parameter int EXTRA_DATA_WIDTH  = 12,
   parameter int DEPTH_LOG2        = 5,
   parameter int ALMOST_FULL_SLACK = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        wrEn,
   input  logic [DATA_WIDTH-1:0]       dataIn,
   input  logic [NUM_PERMUTES-1:0]     permMaskIn,
   input  logic [EXTRA_DATA_WIDTH-1:0] extraIn,
   output logic [DEPTH_LOG2:0]         fifoFullness,
   output logic                        full,
   output logic                        almostFull,
   output logic                        overflow,
   output logic                        outValid,
   input  logic                        outReady,
   output logic [DATA_WIDTH-1:0]       outData,
   output logic [((NUM_PERMUTES > 1) ? $clog2(NUM_PERMUTES) : 1)-1:0] outPermIdx,
   output logic [EXTRA_DATA_WIDTH-1:0] outExtra,
   output logic                        outLast
);

   localparam int IDX_W = (NUM_PERMUTES > 1) ? $clog2(NUM_PERMUTES) : 1;
   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   // Index of the lowest set bit; zero when the mask is empty.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_PERMUTES-1:0] m);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = NUM_PERMUTES - 1; i >= 0; i--) begin
         if (m[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // True when exactly one bit of the mask is set.
   function automatic logic is_onehot(input logic [NUM_PERMUTES-1:0] m);
      return (m != '0) && ((m & (m - NUM_PERMUTES'(1))) == '0);
   endfunction

   // FIFO storage (no reset needed: only slots below the count are ever read)
   logic [DATA_WIDTH-1:0]       mem_data_q  [DEPTH];
   logic [NUM_PERMUTES-1:0]     mem_mask_q  [DEPTH];
   logic [EXTRA_DATA_WIDTH-1:0] mem_extra_q [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q;

   // Holding register: entry currently being serialised, mask shrinks per beat
   logic [DATA_WIDTH-1:0]       hold_data_q;
   logic [NUM_PERMUTES-1:0]     hold_mask_q;
   logic [EXTRA_DATA_WIDTH-1:0] hold_extra_q;

   state_t state_q, state_d;

   logic full_s, wr_req_s, wr_accept_s, pop_s, beat_fire_s, last_s;

   // full is decoded from the registered count, so a same-cycle pop never frees a slot
   assign full_s      = (count_q == DEPTH_CNT);
   assign wr_req_s    = wrEn & (|permMaskIn);
   assign wr_accept_s = wr_req_s & ~full_s;
   assign last_s      = is_onehot(hold_mask_q);
   assign beat_fire_s = (state_q == BURST) & outReady;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and pop decision
   always_comb begin
      state_d = state_q;
      pop_s   = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop_s   = 1'b1;
               state_d = BURST;
            end else begin
               state_d = IDLE;
            end
         end
         BURST: begin
            if (beat_fire_s && last_s) begin
               // Refill back-to-back when an entry is waiting, avoiding a bubble
               if (count_q != '0) begin
                  pop_s   = 1'b1;
                  state_d = BURST;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = BURST;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs, derived from registered state and holding mask only
   always_comb begin
      outValid   = (state_q == BURST);
      outPermIdx = lowest_idx(hold_mask_q);
      outLast    = (state_q == BURST) && last_s;
   end

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (wr_accept_s) begin
         mem_data_q[wr_ptr_q]  <= dataIn;
         mem_mask_q[wr_ptr_q]  <= permMaskIn;
         mem_extra_q[wr_ptr_q] <= extraIn;
      end
   end

   // Occupancy next value
   always_comb begin
      case ({wr_accept_s, pop_s})
         2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
         2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_accept_s ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
         rd_ptr_q   <= pop_s ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
         count_q    <= count_d;
         overflow_q <= overflow_q | (wr_req_s & full_s);
      end
   end

   // Holding register: load on pop, otherwise retire the lowest bit per accepted beat
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data_q  <= '0;
         hold_mask_q  <= '0;
         hold_extra_q <= '0;
      end else if (pop_s) begin
         hold_data_q  <= mem_data_q[rd_ptr_q];
         hold_mask_q  <= mem_mask_q[rd_ptr_q];
         hold_extra_q <= mem_extra_q[rd_ptr_q];
      end else if (beat_fire_s) begin
         hold_mask_q  <= hold_mask_q & (hold_mask_q - NUM_PERMUTES'(1));
      end else begin
         hold_mask_q  <= hold_mask_q;
      end
   end

   assign fifoFullness = count_q;
   assign full         = full_s;
   assign almostFull   = (int'(count_q) >= (DEPTH - ALMOST_FULL_SLACK));
   assign overflow     = overflow_q;
   assign outData      = hold_data_q;
   assign outExtra     = hold_extra_q;

endmodule

// File: tb/tb_permute_burst_input_buffer.sv
module tb_permute_burst_input_buffer;

   localparam int DW = 128;
   localparam int NP = 6;
   localparam int EW = 12;
   localparam int DL = 5;
   localparam int SL = 4;
   localparam int DEPTH = 32;
   localparam int IW = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          wr_en;
   logic [DW-1:0] data_in;
   logic [NP-1:0] mask_in;
   logic [EW-1:0] extra_in;
   logic          out_ready;
   logic [DL:0]   fifo_fullness;
   logic          full, almost_full, overflow, out_valid, out_last;
   logic [DW-1:0] out_data;
   logic [IW-1:0] out_idx;
   logic [EW-1:0] out_extra;

   // second build with 8 permutations
   logic          wr_en8, ready8;
   logic [7:0]    mask8;
   logic [DL:0]   fullness8;
   logic          full8, af8, ovf8, valid8, last8;
   logic [DW-1:0] data8;
   logic [2:0]    idx8;
   logic [EW-1:0] extra8;

   permute_burst_input_buffer #(
      .DATA_WIDTH(DW), .NUM_PERMUTES(NP), .EXTRA_DATA_WIDTH(EW),
      .DEPTH_LOG2(DL), .ALMOST_FULL_SLACK(SL)
   ) u_dut (
      .clk(clk), .rst(rst), .wrEn(wr_en), .dataIn(data_in), .permMaskIn(mask_in),
      .extraIn(extra_in), .fifoFullness(fifo_fullness), .full(full),
      .almostFull(almost_full), .overflow(overflow), .outValid(out_valid),
      .outReady(out_ready), .outData(out_data), .outPermIdx(out_idx),
      .outExtra(out_extra), .outLast(out_last)
   );

   permute_burst_input_buffer #(
      .DATA_WIDTH(DW), .NUM_PERMUTES(8), .EXTRA_DATA_WIDTH(EW),
      .DEPTH_LOG2(DL), .ALMOST_FULL_SLACK(SL)
   ) u_dut8 (
      .clk(clk), .rst(rst), .wrEn(wr_en8), .dataIn(data_in), .permMaskIn(mask8),
      .extraIn(extra_in), .fifoFullness(fullness8), .full(full8),
      .almostFull(af8), .overflow(ovf8), .outValid(valid8),
      .outReady(ready8), .outData(data8), .outPermIdx(idx8),
      .outExtra(extra8), .outLast(last8)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] data;
      logic [NP-1:0] mask;
      logic [EW-1:0] extra;
   } entry_t;

   entry_t        fifo_q[$];
   logic          m_busy = 1'b0;
   logic          m_ovf  = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic [NP-1:0] m_mask = '0;
   logic [EW-1:0] m_extra = '0;

   int errors = 0;
   int checks = 0;

   function automatic int low_idx(input logic [NP-1:0] m);
      for (int i = 0; i < NP; i++) if (m[i]) return i;
      return 0;
   endfunction

   function automatic logic [9:0] model_status();
      return {6'(fifo_q.size()), fifo_q.size() == DEPTH, fifo_q.size() >= DEPTH - SL,
              m_ovf, m_busy};
   endfunction

   function automatic logic [DW+IW+EW:0] model_beat();
      return {m_data, IW'(low_idx(m_mask)), m_extra, $countones(m_mask) == 1};
   endfunction

   wire [9:0]       dut_status = {fifo_fullness, full, almost_full, overflow, out_valid};
   wire [DW+IW+EW:0] dut_beat  = {out_data, out_idx, out_extra, out_last};

   task automatic load_head();
      entry_t h;
      h = fifo_q.pop_front();
      m_data = h.data; m_mask = h.mask; m_extra = h.extra; m_busy = 1'b1;
   endtask

   // Drive one cycle of stimulus, advance the model across the edge, settle #1.
   task automatic tick(input logic wr, input logic [NP-1:0] mask, input logic rdy,
                       input logic do_rst);
      entry_t e;
      logic   pre_full;
      e.data  = {$urandom, $urandom, $urandom, $urandom};
      e.extra = EW'($urandom);
      e.mask  = mask;
      wr_en = wr; mask_in = mask; data_in = e.data; extra_in = e.extra;
      out_ready = rdy; rst = do_rst;
      @(posedge clk);
      if (do_rst) begin
         fifo_q.delete();
         m_busy = 1'b0; m_ovf = 1'b0; m_data = '0; m_mask = '0; m_extra = '0;
      end else begin
         pre_full = (fifo_q.size() == DEPTH);
         if (!m_busy) begin
            if (fifo_q.size() > 0) load_head();
         end else if (rdy) begin
            if ($countones(m_mask) == 1) begin
               if (fifo_q.size() > 0) load_head();
               else begin m_mask = '0; m_busy = 1'b0; end
            end else begin
               m_mask[low_idx(m_mask)] = 1'b0;
            end
         end
         if (wr && mask != '0) begin
            if (pre_full) m_ovf = 1'b1;
            else fifo_q.push_back(e);
         end
      end
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (dut_status !== 10'd0) begin
         errors++; $display("FAIL reset_status got=%h exp=%h", dut_status, 10'd0);
      end
      checks++;
      if (dut_beat !== '0) begin
         errors++; $display("FAIL reset_beat got=%h exp=0", dut_beat);
      end
   endtask

   task automatic test_single();
      int seen_idx[$];
      int seen_last[$];
      int first_valid;
      first_valid = -1;
      tick(1'b0, '0, 1'b1, 1'b1);
      tick(1'b1, 6'b100101, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || fifo_fullness !== 6'd1) begin
         errors++; $display("FAIL single_after_write valid=%b cnt=%0d exp valid=0 cnt=1",
                            out_valid, fifo_fullness);
      end
      for (int t = 2; t <= 6; t++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (dut_status !== model_status()) begin
            errors++; $display("FAIL single_status t=%0d got=%h exp=%h", t, dut_status, model_status());
         end
         if (out_valid) begin
            if (first_valid < 0) first_valid = t;
            seen_idx.push_back(int'(out_idx));
            seen_last.push_back(int'(out_last));
         end
      end
      checks++;
      if (first_valid != 2) begin
         errors++; $display("FAIL single_latency got=%0d edges exp=2", first_valid);
      end
      checks++;
      if (seen_idx.size() != 3 || seen_idx[0] != 0 || seen_idx[1] != 2 || seen_idx[2] != 5 ||
          seen_last[0] != 0 || seen_last[1] != 0 || seen_last[2] != 1) begin
         errors++; $display("FAIL single_beats got n=%0d idx=%p last=%p exp idx 0,2,5 last 0,0,1",
                            seen_idx.size(), seen_idx, seen_last);
      end
   endtask

   task automatic test_back_to_back();
      int seen_idx[$];
      int first_t, last_t;
      first_t = -1; last_t = -1;
      tick(1'b0, '0, 1'b1, 1'b1);
      for (int t = 1; t <= 7; t++) begin
         if (t == 1) tick(1'b1, 6'b000001, 1'b1, 1'b0);
         else if (t == 2) tick(1'b1, 6'b110000, 1'b1, 1'b0);
         else tick(1'b0, '0, 1'b1, 1'b0);
         checks++;
         if (out_valid && dut_beat !== model_beat()) begin
            errors++; $display("FAIL b2b_beat t=%0d got=%h exp=%h", t, dut_beat, model_beat());
         end
         if (out_valid) begin
            seen_idx.push_back(int'(out_idx));
            if (first_t < 0) first_t = t;
            last_t = t;
         end
      end
      checks++;
      if (seen_idx.size() != 3 || seen_idx[0] != 0 || seen_idx[1] != 4 || seen_idx[2] != 5 ||
          last_t - first_t != 2) begin
         errors++; $display("FAIL b2b_sequence got idx=%p span=%0d exp idx 0,4,5 span=2",
                            seen_idx, last_t - first_t);
      end
   endtask

   task automatic test_backpressure();
      logic [IW-1:0] held_idx;
      logic [DW-1:0] held_data;
      int n;
      tick(1'b0, '0, 1'b1, 1'b1);
      tick(1'b1, 6'b111111, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      held_idx = out_idx; held_data = out_data;
      for (int t = 0; t < 5; t++) begin
         tick(1'b0, '0, 1'b0, 1'b0);
         checks++;
         if (out_valid !== 1'b1 || out_idx !== held_idx || out_data !== held_data) begin
            errors++; $display("FAIL stall_hold t=%0d valid=%b idx=%0d exp valid=1 idx=%0d",
                               t, out_valid, out_idx, held_idx);
         end
      end
      checks++;
      if (held_idx !== 3'd1) begin
         errors++; $display("FAIL stall_index got=%0d exp=1", held_idx);
      end
      n = 0;
      while ((m_busy || fifo_q.size() > 0) && n < 20) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         n++;
         checks++;
         if (dut_status !== model_status() || (out_valid && dut_beat !== model_beat())) begin
            errors++; $display("FAIL stall_resume got=%h/%h exp=%h/%h",
                               dut_status, dut_beat, model_status(), model_beat());
         end
      end
   endtask

   task automatic test_fill();
      int n;
      tick(1'b0, '0, 1'b0, 1'b1);
      for (int t = 0; t < 36; t++) begin
         tick(1'b1, NP'($urandom_range(1, 63)), 1'b0, 1'b0);
         checks++;
         if (dut_status !== model_status()) begin
            errors++; $display("FAIL fill_status t=%0d got=%h exp=%h", t, dut_status, model_status());
         end
      end
      tick(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (full !== 1'b1 || overflow !== 1'b1 || fifo_fullness !== 6'd32 || almost_full !== 1'b1) begin
         errors++; $display("FAIL fill_full full=%b ovf=%b cnt=%0d af=%b exp 1 1 32 1",
                            full, overflow, fifo_fullness, almost_full);
      end
      n = 0;
      while ((m_busy || fifo_q.size() > 0) && n < 1000) begin
         tick(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
         n++;
         checks++;
         if (dut_status !== model_status() || (out_valid && dut_beat !== model_beat())) begin
            errors++; $display("FAIL drain n=%0d got=%h/%h exp=%h/%h",
                               n, dut_status, dut_beat, model_status(), model_beat());
         end
      end
      checks++;
      if (n >= 1000 || overflow !== 1'b1) begin
         errors++; $display("FAIL drain_done cycles=%0d ovf=%b exp <1000 ovf=1", n, overflow);
      end
   endtask

   task automatic test_zero_mask();
      for (int t = 0; t < 4; t++) begin
         tick(1'b1, '0, 1'b1, 1'b0);
         checks++;
         if (dut_status !== model_status() || fifo_fullness !== 6'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL zero_mask got=%h exp=%h", dut_status, model_status());
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int t = 0; t < 4; t++) tick(1'b1, 6'b011011, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || fifo_fullness !== 6'd3 || overflow !== 1'b1) begin
         errors++; $display("FAIL pre_reset valid=%b cnt=%0d ovf=%b exp 1 3 1",
                            out_valid, fifo_fullness, overflow);
      end
      tick(1'b0, '0, 1'b1, 1'b1);
      for (int t = 0; t < 4; t++) begin
         checks++;
         if (out_valid !== 1'b0 || fifo_fullness !== 6'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset t=%0d valid=%b cnt=%0d ovf=%b exp 0 0 0",
                               t, out_valid, fifo_fullness, overflow);
         end
         tick(1'b0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_random();
      logic [NP-1:0] m;
      for (int t = 0; t < 400; t++) begin
         m = ($urandom_range(0, 7) == 0) ? '0 : NP'($urandom);
         tick(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 3) != 0), 1'b0);
         checks++;
         if (dut_status !== model_status() || (out_valid && dut_beat !== model_beat())) begin
            errors++; $display("FAIL random t=%0d got=%h/%h exp=%h/%h",
                               t, dut_status, dut_beat, model_status(), model_beat());
         end
      end
   endtask

   task automatic test_np8();
      int seen_idx[$];
      int seen_last[$];
      logic [DW-1:0] wdata;
      tick(1'b0, '0, 1'b1, 1'b1);
      wr_en8 = 1'b1; mask8 = 8'h81;
      tick(1'b0, '0, 1'b1, 1'b0);
      wdata = data_in;
      wr_en8 = 1'b0; mask8 = 8'h00;
      for (int t = 0; t < 5; t++) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         if (valid8) begin
            seen_idx.push_back(int'(idx8));
            seen_last.push_back(int'(last8));
            checks++;
            if (data8 !== wdata) begin
               errors++; $display("FAIL np8_data got=%h exp=%h", data8, wdata);
            end
         end
      end
      checks++;
      if (seen_idx.size() != 2 || seen_idx[0] != 0 || seen_idx[1] != 7 ||
          seen_last[0] != 0 || seen_last[1] != 1) begin
         errors++; $display("FAIL np8_beats got idx=%p last=%p exp idx 0,7 last 0,1",
                            seen_idx, seen_last);
      end
   endtask

   initial begin
      wr_en8 = 1'b0; mask8 = 8'h00; ready8 = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_fill();
      test_zero_mask();
      test_reset_mid();
      test_random();
      test_np8();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
